dff_reg: RTL and testbench

- Parameterised D flip-flop register cell with asynchronous active-high reset.
- Basic storage/delay primitive for datapath and control pipelines.
- Used as a per-stage element in shift-delay chains: data in on one port, registered copy out STAGES cycles later.
- Default configuration (WIDTH=1, STAGES=1) is a plain single-bit DFF that drops in for positional four-port instantiation (clk, reset, d, q).

---
 rtl/dff_reg.sv | 49 ++++
 tb/tb_dff_reg.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dff_reg.sv
// Parameterised multi-stage D flip-flop register with asynchronous active-high reset.
// Define DFF_REG_CHECK_EN to compile in simulation-only X/Z and parameter checks.
module dff_reg #(
  parameter int unsigned WIDTH       = 1,
  parameter logic [63:0] RESET_VALUE = '0,
  parameter int unsigned STAGES      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Cast truncates wide reset values and zero-extends narrow ones.
  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VALUE);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= {STAGES{ResetVal}};
    end else begin
      stage_q[0] <= d;
      for (int unsigned k = 1; k < STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

`ifdef DFF_REG_CHECK_EN
  if (WIDTH == 0 || STAGES == 0) begin : g_bad_param
    $error("dff_reg: invalid parameters WIDTH=%0d STAGES=%0d; both must be >= 1",
           WIDTH, STAGES);
  end

  always @(posedge clk) begin
    if (!reset && $isunknown(d)) begin
      $error("%m: X/Z on d (%b) at time %0t", d, $time);
    end
  end
`else
  if (WIDTH == 0 || STAGES == 0) begin : g_bad_param
    $error("dff_reg: WIDTH and STAGES must be >= 1");
  end
`endif

endmodule

// File: tb/tb_dff_reg.sv
// Directed self-checking bench for dff_reg: reset, async reset, latency, reset value, chaining.
module tb_dff_reg;

  logic clk;
  logic reset;

  logic       d0, q0;
  logic [7:0] d8, q8;
  logic [7:0] dp, qp;
  logic [3:0] drv, qrv;
  logic       cin, c1, c2, c3;

  int errors;
  int checks;

  dff_reg u_def (
    .clk  (clk),
    .reset(reset),
    .d    (d0),
    .q    (q0)
  );

  dff_reg #(.WIDTH(8)) u_w8 (
    .clk  (clk),
    .reset(reset),
    .d    (d8),
    .q    (q8)
  );

  dff_reg #(.WIDTH(8), .STAGES(3)) u_pipe (
    .clk  (clk),
    .reset(reset),
    .d    (dp),
    .q    (qp)
  );

  dff_reg #(.WIDTH(4), .RESET_VALUE(9'h1F3)) u_rv (
    .clk  (clk),
    .reset(reset),
    .d    (drv),
    .q    (qrv)
  );

  // Drop-in four-port positional chain.
  dff_reg u_c1 (clk, reset, cin, c1);
  dff_reg u_c2 (clk, reset, c1, c2);
  dff_reg u_c3 (clk, reset, c2, c3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    d0 = 1'b1; d8 = 8'hA5; dp = 8'h00; drv = 4'h5; cin = 1'b0;

    // Reset held: clk edges ignored.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold_q0", 32'(q0), 32'h0);
    end
    check("rst_hold_q8", 32'(q8), 32'h00);
    check("rst_val_qrv", 32'(qrv), 32'h3);
    check("rst_hold_qp", 32'(qp), 32'h00);

    // Synchronous release, one edge loads d.
    reset = 1'b0;
    tick();
    check("release_q0", 32'(q0), 32'h1);
    check("release_q8", 32'(q8), 32'hA5);
    check("release_qrv", 32'(qrv), 32'h5);

    // Asynchronous assertion between edges.
    #3 reset = 1'b1;
    #1;
    check("async_q8", 32'(q8), 32'h00);
    check("async_qrv", 32'(qrv), 32'h3);
    check("async_q0", 32'(q0), 32'h0);
    tick();
    reset = 1'b0;

    // Pipeline latency: q shows reset value for two edges, then 1,2,3,4.
    for (int i = 0; i < 6; i++) begin
      dp = (i < 4) ? 8'(i + 1) : 8'h00;
      tick();
      check("pipe_lat", 32'(qp), (i >= 2) ? 32'(i - 1) : 32'h0);
    end

    // Fill with 7,8,9 then reset mid-pipeline.
    dp = 8'd7; tick();
    dp = 8'd8; tick();
    dp = 8'd9; tick();
    check("pipe_fill", 32'(qp), 32'd7);
    #3 reset = 1'b1;
    #1;
    check("pipe_async_rst", 32'(qp), 32'h00);
    @(posedge clk);
    #1 reset = 1'b0;
    check("pipe_post_rel", 32'(qp), 32'h00);
    for (int i = 0; i < 4; i++) begin
      dp = 8'(10 + i);
      tick();
      check("pipe_restart", 32'(qp), (i >= 2) ? 32'(10 + i - 2) : 32'h0);
    end

    // Positional chain: single-cycle pulse emerges three edges later.
    cin = 1'b1;
    tick();
    cin = 1'b0;
    check("chain_e1", 32'(c3), 32'h0);
    tick();
    check("chain_e2", 32'(c3), 32'h0);
    tick();
    check("chain_e3", 32'(c3), 32'h1);
    tick();
    check("chain_e4", 32'(c3), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
